// File: rtl/sram_mem_controller_if.sv
// Bus bundle for the memory-stage SRAM controller: the pipeline request and
// response signals plus the external 16-bit SRAM pad signals.
interface sram_mem_controller_if #(
  parameter int SRAM_AW = 18
);
  logic               rd_en;
  logic               wr_en;
  logic [31:0]        address;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic               ready;
  logic [SRAM_AW-1:0] sram_addr;
  logic [15:0]        sram_dq_out;
  logic               sram_dq_oe;
  logic [15:0]        sram_dq_in;
  logic               sram_we_n;
  logic               sram_oe_n;

  // Environment side: the pipeline plus the SRAM device.
  modport master (
    output rd_en, wr_en, address, wdata, sram_dq_in,
    input  rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
  );

  // Controller side.
  modport slave (
    input  rd_en, wr_en, address, wdata, sram_dq_in,
    output rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
  );
endinterface

// File: rtl/sram_mem_controller.sv
// Memory-stage SRAM controller: performs each 32-bit LDR/STR as two 16-bit
// SRAM accesses (low halfword, then high halfword), each held for
// ACCESS_CYCLES clocks, and holds ready low until the word is complete.
module sram_mem_controller #(
  parameter int DATA_BASE     = 1024,
  parameter int SRAM_AW       = 18,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_mem_controller_if.slave bus
);

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  // Everything driven onto the SRAM pads, registered as one unit.
  typedef struct packed {
    logic [SRAM_AW-1:0] addr;
    logic [15:0]        dq_out;
    logic               dq_oe;
    logic               we_n;
    logic               oe_n;
  } pad_t;

  localparam pad_t PAD_IDLE = '{addr: '0, dq_out: '0, dq_oe: 1'b0, we_n: 1'b1, oe_n: 1'b1};

  // Pad values for one halfword phase of a read or a write.
  function automatic pad_t phase_pad(input logic wr, input logic [SRAM_AW-1:0] addr,
                                     input logic [15:0] data);
    pad_t p;
    p      = PAD_IDLE;
    p.addr = addr;
    if (wr) begin
      p.dq_out = data;
      p.dq_oe  = 1'b1;
      p.we_n   = 1'b0;
    end else begin
      p.oe_n = 1'b0;
    end
    return p;
  endfunction

  // Byte address to even halfword index; the subtraction wraps modulo 2^32
  // and the low two byte-address bits never reach the SRAM.
  function automatic logic [SRAM_AW-1:0] half_base(input logic [31:0] byte_addr);
    logic [31:0] off;
    off    = (byte_addr - 32'(DATA_BASE)) >> 1;
    off[0] = 1'b0;
    return off[SRAM_AW-1:0];
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_q, op_d;
  logic [SRAM_AW-1:0] base_q, base_d;
  logic [31:0]        wdat_q, wdat_d;
  logic [31:0]        rdata_q, rdata_d;
  pad_t               pad_q, pad_d;

  // Next-state logic; pad values are computed for the state being entered so
  // the registered pads line up with the LO/HI cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    base_d  = base_q;
    wdat_d  = wdat_q;
    rdata_d = rdata_q;
    pad_d   = PAD_IDLE;
    case (state_q)
      IDLE: begin
        if (bus.wr_en | bus.rd_en) begin
          op_d    = bus.wr_en;
          base_d  = half_base(bus.address);
          wdat_d  = bus.wdata;
          cnt_d   = '0;
          state_d = LO;
          pad_d   = phase_pad(bus.wr_en, half_base(bus.address), bus.wdata[15:0]);
        end
      end
      LO: begin
        cnt_d = cnt_q + CNT_W'(1);
        pad_d = phase_pad(op_q, base_q, wdat_q[15:0]);
        if (cnt_q == CNT_LAST) begin
          if (!op_q) rdata_d[15:0] = bus.sram_dq_in;
          cnt_d   = '0;
          state_d = HI;
          pad_d   = phase_pad(op_q, base_q + SRAM_AW'(1), wdat_q[31:16]);
        end
      end
      HI: begin
        cnt_d = cnt_q + CNT_W'(1);
        pad_d = phase_pad(op_q, base_q + SRAM_AW'(1), wdat_q[31:16]);
        if (cnt_q == CNT_LAST) begin
          if (!op_q) rdata_d[31:16] = bus.sram_dq_in;
          cnt_d   = '0;
          state_d = DONE;
          pad_d   = PAD_IDLE;
        end
      end
      DONE: begin
        // Enables are still high here; the pipeline advances on this edge.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset also returns the pads to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      base_q  <= '0;
      wdat_q  <= '0;
      rdata_q <= '0;
      pad_q   <= PAD_IDLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      base_q  <= base_d;
      wdat_q  <= wdat_d;
      rdata_q <= rdata_d;
      pad_q   <= pad_d;
    end
  end

  // In IDLE a new request stalls the pipeline in its first cycle.
  assign bus.ready       = (state_q == IDLE) ? ~(bus.rd_en | bus.wr_en) : (state_q == DONE);
  assign bus.rdata       = rdata_q;
  assign bus.sram_addr   = pad_q.addr;
  assign bus.sram_dq_out = pad_q.dq_out;
  assign bus.sram_dq_oe  = pad_q.dq_oe;
  assign bus.sram_we_n   = pad_q.we_n;
  assign bus.sram_oe_n   = pad_q.oe_n;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: two instances (ACCESS_CYCLES 2 and 1), each
// with a behavioural 16-bit SRAM; vector table plus hand-written sequences.
module tb_sram_mem_controller;
  localparam int AW = 18;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_mem_controller_if #(.SRAM_AW(AW)) if0 ();
  sram_mem_controller_if #(.SRAM_AW(AW)) if1 ();

  sram_mem_controller #(.DATA_BASE(1024), .SRAM_AW(AW), .ACCESS_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .bus(if0));
  sram_mem_controller #(.DATA_BASE(1024), .SRAM_AW(AW), .ACCESS_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1));

  logic [15:0] mem0 [0:(1<<AW)-1];
  logic [15:0] mem1 [0:(1<<AW)-1];

  // Behavioural SRAMs: write on the clock while we_n is low, read combinationally.
  always @(posedge clk) begin
    if (!if0.sram_we_n && if0.sram_dq_oe) mem0[if0.sram_addr] <= if0.sram_dq_out;
    if (!if1.sram_we_n && if1.sram_dq_oe) mem1[if1.sram_addr] <= if1.sram_dq_out;
  end
  assign if0.sram_dq_in = if0.sram_oe_n ? 16'h0000 : mem0[if0.sram_addr];
  assign if1.sram_dq_in = if1.sram_oe_n ? 16'h0000 : mem1[if1.sram_addr];

  typedef struct {
    int          dut;
    bit          rd;
    bit          wr;
    bit          pert;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [17:0] base;
    logic [31:0] exp_rdata;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [$];
  vec_t vecs [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int d, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] w);
    if (d == 0) begin
      if0.rd_en = rd; if0.wr_en = wr; if0.address = a; if0.wdata = w;
    end else begin
      if1.rd_en = rd; if1.wr_en = wr; if1.address = a; if1.wdata = w;
    end
  endtask

  // {ready, we_n, oe_n, dq_oe, dq_out, addr}
  function automatic logic [37:0] obs(input int d);
    if (d == 0)
      return {if0.ready, if0.sram_we_n, if0.sram_oe_n, if0.sram_dq_oe, if0.sram_dq_out, if0.sram_addr};
    return {if1.ready, if1.sram_we_n, if1.sram_oe_n, if1.sram_dq_oe, if1.sram_dq_out, if1.sram_addr};
  endfunction

  // kind: 0 = idle bus, 1 = write phase, 2 = read phase
  function automatic logic [37:0] mk(input bit rdy, input int kind, input logic [17:0] a,
                                     input logic [15:0] dq);
    case (kind)
      1:       return {rdy, 1'b0, 1'b1, 1'b1, dq, a};
      2:       return {rdy, 1'b1, 1'b0, 1'b0, 16'h0000, a};
      default: return {rdy, 1'b1, 1'b1, 1'b0, 16'h0000, 18'h0};
    endcase
  endfunction

  function automatic logic [31:0] rdata_of(input int d);
    return (d == 0) ? if0.rdata : if1.rdata;
  endfunction

  function automatic logic [15:0] mem_of(input int d, input logic [17:0] a);
    return (d == 0) ? mem0[a] : mem1[a];
  endfunction

  function automatic vec_t mkv(input int d, input bit rd, input bit wr, input bit pert,
                               input logic [31:0] a, input logic [31:0] w,
                               input logic [17:0] b, input logic [31:0] e);
    vec_t v;
    v.dut = d; v.rd = rd; v.wr = wr; v.pert = pert;
    v.addr = a; v.wdata = w; v.base = b; v.exp_rdata = e;
    return v;
  endfunction

  // One complete access, checked every cycle from request to DONE.
  task automatic run_access(input vec_t v, input int idx);
    int          n;
    int          kind;
    logic [17:0] b1;
    logic [31:0] e;
    n    = (v.dut == 1) ? 1 : 2;
    kind = v.wr ? 1 : 2;
    b1   = v.base + 18'd1;
    exp_q.push_back(v.exp_rdata);
    @(posedge clk); #1;
    drive(v.dut, v.rd, v.wr, v.addr, v.wdata);
    for (int k = 0; k <= 2*n+1; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        if (v.pert) drive(v.dut, v.wr, v.rd, ~v.addr, ~v.wdata);
      end
      @(negedge clk);
      if (k == 0)
        check($sformatf("v%0d c%0d req", idx, k), obs(v.dut), mk(0, 0, 0, 0));
      else if (k <= n)
        check($sformatf("v%0d c%0d lo", idx, k), obs(v.dut), mk(0, kind, v.base, v.wdata[15:0]));
      else if (k <= 2*n)
        check($sformatf("v%0d c%0d hi", idx, k), obs(v.dut), mk(0, kind, b1, v.wdata[31:16]));
      else begin
        check($sformatf("v%0d c%0d done", idx, k), obs(v.dut), mk(1, 0, 0, 0));
        if (exp_q.size() == 0) check($sformatf("v%0d sb empty", idx), 1, 0);
        else begin
          e = exp_q.pop_front();
          check($sformatf("v%0d rdata", idx), rdata_of(v.dut), e);
        end
      end
    end
    if (v.wr) begin
      check($sformatf("v%0d mem lo", idx), mem_of(v.dut, v.base), v.wdata[15:0]);
      check($sformatf("v%0d mem hi", idx), mem_of(v.dut, b1), v.wdata[31:16]);
    end
    @(posedge clk); #1;
    drive(v.dut, 0, 0, 0, 0);
    @(negedge clk);
    check($sformatf("v%0d idle after", idx), obs(v.dut), mk(1, 0, 0, 0));
  endtask

  // Two loads (1024 then 1028) with enables held high throughout.
  task automatic back_to_back(input int d, input logic [31:0] e0, input logic [31:0] e1);
    int          n;
    int          s;
    int          last;
    bit          er;
    logic [17:0] ea;
    logic [31:0] e;
    logic [37:0] o;
    n    = (d == 1) ? 1 : 2;
    s    = 2*n + 2;
    last = 4*n + 3;
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    @(posedge clk); #1;
    drive(d, 1, 0, 32'd1024, 0);
    for (int k = 0; k <= last; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        if (k == s) drive(d, 1, 0, 32'd1028, 0);
      end
      @(negedge clk);
      er = (k == 2*n+1) || (k == last);
      if (k >= 1 && k <= n)                ea = 18'd0;
      else if (k >= n+1 && k <= 2*n)       ea = 18'd1;
      else if (k >= s+1 && k <= s+n)       ea = 18'd2;
      else if (k >= s+n+1 && k <= s+2*n)   ea = 18'd3;
      else                                 ea = 18'd0;
      o = obs(d);
      check($sformatf("b2b d%0d c%0d ready/addr", d, k), {o[37], o[17:0]}, {er, ea});
      if (er) begin
        if (exp_q.size() == 0) check($sformatf("b2b d%0d sb empty", d), 1, 0);
        else begin
          e = exp_q.pop_front();
          check($sformatf("b2b d%0d c%0d rdata", d, k), rdata_of(d), e);
        end
      end
    end
    @(posedge clk); #1;
    drive(d, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = mkv(0, 0, 1, 0, 32'd1032, 32'hDEADBEEF, 18'd4,       32'h00000000);
    vecs[1]  = mkv(0, 1, 0, 0, 32'd1032, 32'h00000000, 18'd4,       32'hDEADBEEF);
    vecs[2]  = mkv(0, 1, 1, 0, 32'd1024, 32'h12345678, 18'd0,       32'hDEADBEEF);
    vecs[3]  = mkv(0, 1, 0, 0, 32'd1024, 32'h00000000, 18'd0,       32'h12345678);
    vecs[4]  = mkv(0, 1, 0, 1, 32'd1035, 32'h00000000, 18'd4,       32'hDEADBEEF);
    vecs[5]  = mkv(0, 0, 1, 1, 32'd1020, 32'hA5A55A5A, 18'h3FFFE,   32'hDEADBEEF);
    vecs[6]  = mkv(0, 1, 0, 0, 32'd1020, 32'h00000000, 18'h3FFFE,   32'hA5A55A5A);
    vecs[7]  = mkv(0, 0, 1, 0, 32'd2050, 32'hCAFEF00D, 18'd512,     32'hA5A55A5A);
    vecs[8]  = mkv(0, 1, 0, 0, 32'd2048, 32'h00000000, 18'd512,     32'hCAFEF00D);
    vecs[9]  = mkv(0, 0, 1, 0, 32'd1028, 32'h600DCAFE, 18'd2,       32'hCAFEF00D);
    vecs[10] = mkv(1, 0, 1, 0, 32'd1032, 32'h0F0F1E1E, 18'd4,       32'h00000000);
    vecs[11] = mkv(1, 1, 0, 0, 32'd1032, 32'h00000000, 18'd4,       32'h0F0F1E1E);
    vecs[12] = mkv(1, 1, 1, 0, 32'd1028, 32'h55AA33CC, 18'd2,       32'h0F0F1E1E);
    vecs[13] = mkv(1, 0, 1, 0, 32'd1024, 32'h0BADF00D, 18'd0,       32'h0F0F1E1E);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset bus d0", obs(0), mk(1, 0, 0, 0));
    check("reset rdata d0", if0.rdata, 32'h0);
    check("reset bus d1", obs(1), mk(1, 0, 0, 0));
    check("reset rdata d1", if1.rdata, 32'h0);

    foreach (vecs[i]) run_access(vecs[i], i);

    // Reset during the first HI cycle of a store.
    @(posedge clk); #1;
    drive(0, 0, 1, 32'd1032, 32'h11112222);
    @(negedge clk);
    check("rst seq c0", obs(0), mk(0, 0, 0, 0));
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("rst seq c%0d lo", k), obs(0), mk(0, 1, 18'd4, 16'h2222));
    end
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("rst seq c3 hi", obs(0), mk(0, 1, 18'd5, 16'h1111));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst seq c4 idle", obs(0), mk(1, 0, 0, 0));
    check("rst seq rdata", if0.rdata, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst seq c5 idle", obs(0), mk(1, 0, 0, 0));
    // The HI write cycle was on the bus before reset took effect, so both
    // halfwords of the partial store landed.
    run_access(mkv(0, 1, 0, 0, 32'd1032, 32'h0, 18'd4, 32'h11112222), 100);

    back_to_back(0, 32'h12345678, 32'h600DCAFE);
    back_to_back(1, 32'h0BADF00D, 32'h55AA33CC);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
